// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline control types: stage indices,
// hazard FSM states and the per-stage control bundle.
package pipeline_hazard_ctrl_pkg;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  typedef enum logic {
    RUN      = 1'b0,
    EXC_WAIT = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] bubble;
    logic [3:0] nullify;
    logic [3:0] keep_exception;
  } stage_ctrl_t;

endpackage

// File: rtl/mdu_busy_counter.sv
// MDU busy countdown: loads on an accepted start,
// clears on a pipeline flush, else counts down.
module mdu_busy_counter #(
  parameter int MDU_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic flush,
  output logic busy,
  output logic cancel
);

  localparam int CW = $clog2(MDU_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign busy   = |cnt_q;
  assign cancel = flush & busy;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CW'(MDU_CYCLES);
    end else if (busy) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/bubble/nullify,
// PC hold, exception redirect and wrong-path kill tracking.
module pipeline_hazard_ctrl #(
  parameter int MDU_CYCLES  = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   exception_m,
  input  logic                   eret_m,
  input  logic                   dmem_wait,
  input  logic                   imem_wait,
  input  logic                   load_use_d,
  input  logic                   hilo_read_d,
  input  logic                   mdu_start,
  input  logic                   redirect_e,
  output logic [3:0]             stall,
  output logic [3:0]             bubble,
  output logic [3:0]             nullify,
  output logic [3:0]             keep_exception,
  output logic                   pc_stall,
  output logic                   exc_redirect,
  output logic                   mdu_busy,
  output logic                   mdu_cancel,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  import pipeline_hazard_ctrl_pkg::*;

  ctrl_state_t state_q, state_d;
  logic        pend_q, pend_d;
  logic [STALL_CNT_W-1:0] sc_q, sc_d;

  stage_ctrl_t ctrl;
  logic flush;
  logic flush_run;
  logic start_ok;
  logic ifid_frz;
  logic idex_frz;
  logic redir_smp;
  logic pc_stall_c;
  logic exc_redir_c;

  assign flush = exception_m | eret_m;

  always_comb begin
    ctrl        = '0;
    state_d     = state_q;
    pend_d      = pend_q;
    flush_run   = 1'b0;
    start_ok    = 1'b0;
    ifid_frz    = 1'b0;
    idex_frz    = 1'b0;
    redir_smp   = 1'b0;
    pc_stall_c  = 1'b0;
    exc_redir_c = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        RUN: begin
          if (flush) begin
            flush_run                   = 1'b1;
            ctrl.nullify                = 4'b1111;
            ctrl.keep_exception[MEMWB]  = exception_m;
            pend_d                      = 1'b0;
            pc_stall_c                  = 1'b1;
            if (!imem_wait) begin
              exc_redir_c = 1'b1;
            end else begin
              state_d = EXC_WAIT;
            end
          end else begin
            if (dmem_wait) begin
              pc_stall_c          = 1'b1;
              ctrl.stall[EXMEM]   = 1'b1;
              ctrl.bubble[IDEX]   = 1'b1;
              ctrl.bubble[IFID]   = 1'b1;
              ctrl.nullify[MEMWB] = 1'b1;
            end else if ((hilo_read_d & mdu_busy)
                         | load_use_d) begin
              pc_stall_c         = 1'b1;
              ctrl.stall[IFID]   = 1'b1;
              ctrl.nullify[IDEX] = 1'b1;
            end else if (imem_wait) begin
              pc_stall_c         = 1'b1;
              ctrl.nullify[IFID] = 1'b1;
            end
            ifid_frz  = ctrl.stall[IFID] | ctrl.bubble[IFID];
            idex_frz  = ctrl.stall[IDEX] | ctrl.bubble[IDEX];
            redir_smp = redirect_e & ~idex_frz;
            start_ok  = mdu_start & ~idex_frz;
            // kill the wrong-path fetch now and the next one
            if ((redir_smp | pend_q) & ~ifid_frz) begin
              ctrl.nullify[IFID] = 1'b1;
            end
            if (redir_smp) begin
              pend_d = 1'b1;
            end else if (pend_q & ~ifid_frz & ~imem_wait) begin
              pend_d = 1'b0;
            end
          end
        end
        EXC_WAIT: begin
          ctrl.nullify[2:0] = 3'b111;
          pc_stall_c        = 1'b1;
          if (!imem_wait) begin
            exc_redir_c = 1'b1;
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    sc_d = sc_q;
    if (pc_stall_c && !(&sc_q)) begin
      sc_d = sc_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sc_q    <= sc_d;
    end
  end

  mdu_busy_counter #(
    .MDU_CYCLES(MDU_CYCLES)
  ) u_mdu (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start_ok),
    .flush  (flush_run),
    .busy   (mdu_busy),
    .cancel (mdu_cancel)
  );

  assign stall          = ctrl.stall;
  assign bubble         = ctrl.bubble;
  assign nullify        = ctrl.nullify;
  assign keep_exception = ctrl.keep_exception;
  assign pc_stall       = pc_stall_c;
  assign exc_redirect   = exc_redir_c;
  assign stall_cycles   = sc_q;

  for (genvar g = 0; g < 4; g++) begin : g_chk
    a_onehot: assert property (
      @(posedge clk) disable iff (!reset_n)
      $onehot0({stall[g], bubble[g], nullify[g]}));
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table plus
// multi-cycle sequences checked through an expect queue.
module tb_pipeline_hazard_ctrl;

  localparam int MC = 4;
  localparam int SW = 5;

  localparam logic [7:0] EXC = 8'h80;
  localparam logic [7:0] ERT = 8'h40;
  localparam logic [7:0] DW  = 8'h20;
  localparam logic [7:0] IW  = 8'h10;
  localparam logic [7:0] LU  = 8'h08;
  localparam logic [7:0] HI  = 8'h04;
  localparam logic [7:0] MS  = 8'h02;
  localparam logic [7:0] RD  = 8'h01;
  localparam logic [7:0] NO  = 8'h00;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] bu;
    logic [3:0] nu;
    logic [3:0] ke;
    logic       pc;
    logic       xr;
    logic       busy;
    logic       canc;
  } out_t;

  typedef struct {
    logic [7:0] i;
    out_t       o;
    string      nm;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic exception_m, eret_m, dmem_wait, imem_wait;
  logic load_use_d, hilo_read_d, mdu_start, redirect_e;
  logic [3:0] stall, bubble, nullify, keep_exception;
  logic pc_stall, exc_redirect, mdu_busy, mdu_cancel;
  logic [SW-1:0] stall_cycles;

  out_t exp_q[$];
  logic [SW-1:0] exp_sc;
  int n_cmp = 0;
  int n_err = 0;
  vec_t vt[10];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MDU_CYCLES (MC),
    .STALL_CNT_W(SW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .exception_m   (exception_m),
    .eret_m        (eret_m),
    .dmem_wait     (dmem_wait),
    .imem_wait     (imem_wait),
    .load_use_d    (load_use_d),
    .hilo_read_d   (hilo_read_d),
    .mdu_start     (mdu_start),
    .redirect_e    (redirect_e),
    .stall         (stall),
    .bubble        (bubble),
    .nullify       (nullify),
    .keep_exception(keep_exception),
    .pc_stall      (pc_stall),
    .exc_redirect  (exc_redirect),
    .mdu_busy      (mdu_busy),
    .mdu_cancel    (mdu_cancel),
    .stall_cycles  (stall_cycles)
  );

  function automatic out_t mk(
    input logic [3:0] st, input logic [3:0] bu,
    input logic [3:0] nu, input logic [3:0] ke,
    input logic pc, input logic xr,
    input logic busy, input logic canc);
    mk = '{st, bu, nu, ke, pc, xr, busy, canc};
  endfunction

  task automatic drive(input logic [7:0] v);
    {exception_m, eret_m, dmem_wait, imem_wait,
     load_use_d, hilo_read_d, mdu_start, redirect_e} = v;
  endtask

  task automatic compare(input string nm);
    out_t a;
    out_t e;
    a = '{stall, bubble, nullify, keep_exception,
          pc_stall, exc_redirect, mdu_busy, mdu_cancel};
    e = exp_q.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got st=%b bu=%b nu=%b ke=%b pc/xr/busy/canc=%b%b%b%b want st=%b bu=%b nu=%b ke=%b pc/xr/busy/canc=%b%b%b%b",
        nm, a.st, a.bu, a.nu, a.ke, a.pc, a.xr, a.busy, a.canc,
        e.st, e.bu, e.nu, e.ke, e.pc, e.xr, e.busy, e.canc);
    end
    n_cmp++;
    if (stall_cycles !== exp_sc) begin
      n_err++;
      $display("FAIL %s stall_cycles: got %0d want %0d",
        nm, stall_cycles, exp_sc);
    end
    if (e.pc && !(&exp_sc)) exp_sc = exp_sc + 1'b1;
  endtask

  task automatic step(input logic [7:0] v, input out_t e,
                      input string nm);
    @(negedge clk);
    drive(v);
    exp_q.push_back(e);
    #2;
    compare(nm);
  endtask

  out_t Z, LUo, DWo, IWo, BSo;

  initial begin
    Z   = mk(4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
    LUo = mk(4'h1, 4'h0, 4'h2, 4'h0, 1, 0, 0, 0);
    DWo = mk(4'h4, 4'h3, 4'h8, 4'h0, 1, 0, 0, 0);
    IWo = mk(4'h0, 4'h0, 4'h1, 4'h0, 1, 0, 0, 0);
    BSo = mk(4'h1, 4'h0, 4'h2, 4'h0, 1, 0, 1, 0);

    vt[0] = '{NO, Z, "idle"};
    vt[1] = '{LU, LUo, "load_use"};
    vt[2] = '{DW, DWo, "dmem_wait"};
    vt[3] = '{IW, IWo, "imem_wait"};
    vt[4] = '{DW | LU, DWo, "dmem_over_lu"};
    vt[5] = '{LU | IW, LUo, "lu_over_imem"};
    vt[6] = '{HI, Z, "hilo_idle_mdu"};
    vt[7] = '{EXC, mk(4'h0, 4'h0, 4'hF, 4'h8, 1, 1, 0, 0),
              "exc_no_iwait"};
    vt[8] = '{ERT, mk(4'h0, 4'h0, 4'hF, 4'h0, 1, 1, 0, 0),
              "eret_no_iwait"};
    vt[9] = '{EXC | DW, mk(4'h0, 4'h0, 4'hF, 4'h8, 1, 1, 0, 0),
              "exc_over_dmem"};

    exp_sc  = '0;
    reset_n = 1'b0;
    drive(8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(Z);
    #2;
    compare("reset_all_high");
    @(negedge clk);
    drive(NO);
    reset_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      step(vt[k].i, vt[k].o, vt[k].nm);
    end

    step(LU, LUo, "lu_once");
    step(NO, Z, "lu_after");

    for (int k = 0; k < 3; k++) step(DW, DWo, "dmem3");
    step(NO, Z, "dmem3_after");

    step(MS, Z, "mdu_start");
    for (int k = 0; k < MC; k++) step(HI, BSo, "mdu_hazard");
    step(HI, Z, "mdu_done");
    step(NO, Z, "mdu_idle");

    step(EXC | IW, mk(4'h0, 4'h0, 4'hF, 4'h8, 1, 0, 0, 0),
         "exc_iwait0");
    step(IW, mk(4'h0, 4'h0, 4'h7, 4'h0, 1, 0, 0, 0),
         "exc_wait1");
    step(IW | DW | LU | RD | MS,
         mk(4'h0, 4'h0, 4'h7, 4'h0, 1, 0, 0, 0),
         "exc_wait_ignore");
    step(NO, mk(4'h0, 4'h0, 4'h7, 4'h0, 1, 1, 0, 0),
         "exc_redirect");
    step(NO, Z, "exc_after");

    step(RD | LU, LUo, "redir_lu");
    step(NO, mk(4'h0, 4'h0, 4'h1, 4'h0, 0, 0, 0, 0),
         "redir_pend_kill");
    step(NO, Z, "redir_pend_clr");

    step(RD, mk(4'h0, 4'h0, 4'h1, 4'h0, 0, 0, 0, 0),
         "redir_free");
    step(IW, IWo, "redir_iwait");
    step(NO, mk(4'h0, 4'h0, 4'h1, 4'h0, 0, 0, 0, 0),
         "redir_fetch_kill");
    step(NO, Z, "redir_done");

    step(RD | DW, DWo, "redir_frozen");
    step(NO, Z, "redir_not_smp");

    step(MS, Z, "mdu2_start");
    step(NO, mk(4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0),
         "mdu2_busy");
    step(ERT, mk(4'h0, 4'h0, 4'hF, 4'h0, 1, 1, 1, 1),
         "eret_cancel");
    step(NO, Z, "eret_cancel_after");

    step(EXC | MS, mk(4'h0, 4'h0, 4'hF, 4'h8, 1, 1, 0, 0),
         "start_in_flush");
    step(NO, Z, "start_in_flush_nb");
    step(DW | MS, DWo, "start_frozen");
    step(NO, Z, "start_frozen_nb");

    step(MS, Z, "reload_start");
    step(NO, mk(4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0),
         "reload_busy");
    step(MS, mk(4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0),
         "reload_again");
    for (int k = 0; k < MC; k++) begin
      step(NO, mk(4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0),
           "reload_count");
    end
    step(NO, Z, "reload_done");

    for (int k = 0; k < 12; k++) step(LU, LUo, "sat_stall");
    step(NO, Z, "sat_final");
    n_cmp++;
    if (stall_cycles !== {SW{1'b1}}) begin
      n_err++;
      $display("FAIL stall_sat: got %0d want %0d",
        stall_cycles, {SW{1'b1}});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
